// File: rtl/sliding_window_fp16.sv
// Turns a raster-order FP16 pixel stream into WINDOW_HEIGHT x WINDOW_WIDTH windows, 1-cycle latency.
// Build option ZERO_PAD_EN: emit a window for every pixel with out-of-frame taps forced to +0.0.
//
// frame_state | meaning
// IDLE        | after reset or after the last pixel of a frame
// ACTIVE      | pixels of a frame are being accepted
module sliding_window_fp16 #(
  parameter  int EXP_WIDTH     = 5,
  parameter  int FRAC_WIDTH    = 10,
  parameter  int WINDOW_WIDTH  = 3,
  parameter  int WINDOW_HEIGHT = 3,
  parameter  int IMG_WIDTH     = 640,
  parameter  int IMG_HEIGHT    = 480,
  localparam int FP_WIDTH_REG  = 1 + EXP_WIDTH + FRAC_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [FP_WIDTH_REG-1:0] data_i,
  input  logic                    valid_i,
  input  logic                    sof_i,
  output logic [FP_WIDTH_REG-1:0] window_o [WINDOW_HEIGHT][WINDOW_WIDTH],
  output logic [15:0]             col_o,
  output logic [15:0]             row_o,
  output logic                    valid_o,
  output logic                    eof_o
);
  localparam int LB_NUM = WINDOW_HEIGHT - 1;
  localparam int ADDR_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [15:0] COL_LAST = 16'(IMG_WIDTH - 1);
  localparam logic [15:0] ROW_LAST = 16'(IMG_HEIGHT - 1);
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  logic [0:0]              frame_state_q, frame_state_d;
  logic [15:0]             col_q, col_d, row_q, row_d;
  logic [15:0]             pix_col, pix_row;
  logic [15:0]             col_out_q, row_out_q;
  logic                    valid_q, valid_d, eof_q, eof_d;
  logic                    last_pix;
  logic [ADDR_W-1:0]       lb_addr;
  logic [FP_WIDTH_REG-1:0] lb_mem [LB_NUM][IMG_WIDTH];
  logic [FP_WIDTH_REG-1:0] lb_rd  [LB_NUM];
  logic [FP_WIDTH_REG-1:0] tap_q  [WINDOW_HEIGHT][WINDOW_WIDTH];
  logic [FP_WIDTH_REG-1:0] tap_d  [WINDOW_HEIGHT][WINDOW_WIDTH];

  // A start-of-frame pixel is always placed at (0,0), whatever the counters say.
  assign pix_col  = sof_i ? 16'd0 : col_q;
  assign pix_row  = sof_i ? 16'd0 : row_q;
  assign lb_addr  = pix_col[ADDR_W-1:0];
  assign last_pix = (pix_col == COL_LAST) && (pix_row == ROW_LAST);

  always_comb begin
    for (int k = 0; k < LB_NUM; k++) lb_rd[k] = lb_mem[k][lb_addr];
  end

  // Buffer k holds line (row-1-k); each accept pushes the column one line further back.
  always_ff @(posedge clk_i) begin
    if (valid_i && !rst_i) begin
      lb_mem[0][lb_addr] <= data_i;
      for (int k = 1; k < LB_NUM; k++) lb_mem[k][lb_addr] <= lb_rd[k-1];
    end
  end

  always_comb begin
    col_d         = col_q;
    row_d         = row_q;
    frame_state_d = frame_state_q;
    if (valid_i) begin
      if (pix_col == COL_LAST) begin
        col_d = 16'd0;
        row_d = (pix_row == ROW_LAST) ? 16'd0 : pix_row + 16'd1;
      end else begin
        col_d = pix_col + 16'd1;
        row_d = pix_row;
      end
      frame_state_d = last_pix ? IDLE : ACTIVE;
    end
  end

  assign eof_d = valid_i && last_pix && (frame_state_q == ACTIVE);

  always_comb begin
    for (int r = 0; r < WINDOW_HEIGHT; r++)
      for (int c = 0; c < WINDOW_WIDTH; c++) tap_d[r][c] = tap_q[r][c];
    if (valid_i) begin
      for (int r = 0; r < WINDOW_HEIGHT; r++)
        for (int c = 0; c < WINDOW_WIDTH - 1; c++) tap_d[r][c] = tap_q[r][c+1];
      for (int r = 0; r < LB_NUM; r++) tap_d[r][WINDOW_WIDTH-1] = lb_rd[LB_NUM-1-r];
      tap_d[WINDOW_HEIGHT-1][WINDOW_WIDTH-1] = data_i;
`ifdef ZERO_PAD_EN
      // Masked taps stay masked as they shift, since their source coordinate is unchanged.
      for (int r = 0; r < WINDOW_HEIGHT; r++)
        for (int c = 0; c < WINDOW_WIDTH; c++)
          if ((int'(pix_row) < WINDOW_HEIGHT - 1 - r) || (int'(pix_col) < WINDOW_WIDTH - 1 - c))
            tap_d[r][c] = '0;
`endif
    end
  end

`ifdef ZERO_PAD_EN
  assign valid_d = valid_i;
`else
  logic win_full;
  assign win_full = (pix_col >= 16'(WINDOW_WIDTH - 1)) && (pix_row >= 16'(WINDOW_HEIGHT - 1));
  assign valid_d  = valid_i && win_full;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      frame_state_q <= IDLE;
      col_q         <= 16'd0;
      row_q         <= 16'd0;
      col_out_q     <= 16'd0;
      row_out_q     <= 16'd0;
      valid_q       <= 1'b0;
      eof_q         <= 1'b0;
      for (int r = 0; r < WINDOW_HEIGHT; r++)
        for (int c = 0; c < WINDOW_WIDTH; c++) tap_q[r][c] <= '0;
    end else begin
      frame_state_q <= frame_state_d;
      col_q         <= col_d;
      row_q         <= row_d;
      valid_q       <= valid_d;
      eof_q         <= eof_d;
      for (int r = 0; r < WINDOW_HEIGHT; r++)
        for (int c = 0; c < WINDOW_WIDTH; c++) tap_q[r][c] <= tap_d[r][c];
      if (valid_i) begin
        col_out_q <= pix_col;
        row_out_q <= pix_row;
      end
    end
  end

  assign window_o = tap_q;
  assign col_o    = col_out_q;
  assign row_o    = row_out_q;
  assign valid_o  = valid_q;
  assign eof_o    = eof_q;

endmodule

// File: tb/tb_sliding_window_fp16.sv
// Scoreboard bench for sliding_window_fp16: a frame-image reference model predicts every cycle's
// outputs; a negedge monitor pops and compares.
module tb_sliding_window_fp16;
  localparam int W  = 3;
  localparam int H  = 3;
  localparam int IW = 4;
  localparam int IH = 3;
  localparam int DW = 16;
  localparam int WB = W * H * DW;

  logic          clk_i = 1'b0;
  logic          rst_i, valid_i, sof_i;
  logic [DW-1:0] data_i;
  logic [DW-1:0] window_o [H][W];
  logic [15:0]   col_o, row_o;
  logic          valid_o, eof_o;

  sliding_window_fp16 #(
    .EXP_WIDTH(5), .FRAC_WIDTH(10), .WINDOW_WIDTH(W), .WINDOW_HEIGHT(H),
    .IMG_WIDTH(IW), .IMG_HEIGHT(IH)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .valid_i(valid_i), .sof_i(sof_i),
    .window_o(window_o), .col_o(col_o), .row_o(row_o), .valid_o(valid_o), .eof_o(eof_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0]   cyc;
    logic          vld;
    logic          eof;
    logic [15:0]   col;
    logic [15:0]   row;
    logic          chkw;
    logic [WB-1:0] win;
  } exp_t;

  exp_t cyc_q[$];
  exp_t win_q[$];
  int   cyc_n = 0;
  int   checks = 0;
  int   failures = 0;
  bit   done = 1'b0;

  always @(posedge clk_i) cyc_n <= cyc_n + 1;

  logic [WB-1:0] dut_win;
  always_comb begin
    dut_win = '0;
    for (int i = 0; i < H; i++)
      for (int j = 0; j < W; j++) dut_win[(i*W+j)*DW +: DW] = window_o[i][j];
  end

  // Reference model: the current frame as an image plus the next pixel position.
  int            m_col, m_row;
  logic [DW-1:0] img [IH][IW];
  logic [15:0]   out_col, out_row;
  bit            win_known;
  logic [WB-1:0] last_win;

  task automatic step(input bit r, input bit v, input bit s, input logic [DW-1:0] d);
    exp_t          e;
    int            c, rw, sr, sc;
    bit            full, emit;
    logic [WB-1:0] w;
    @(posedge clk_i);
    #1;
    rst_i = r; valid_i = v; sof_i = s; data_i = d;
    e = '0;
    e.cyc = cyc_n;
    if (r) begin
      m_col = 0; m_row = 0; out_col = 0; out_row = 0;
      win_known = 1'b1; last_win = '0;
      e.chkw = 1'b1;
    end else if (v) begin
      c  = s ? 0 : m_col;
      rw = s ? 0 : m_row;
      img[rw][c] = d;
      w = '0;
      full = 1'b1;
      for (int i = 0; i < H; i++)
        for (int j = 0; j < W; j++) begin
          sr = rw - (H - 1 - i);
          sc = c - (W - 1 - j);
          if (sr < 0 || sc < 0) full = 1'b0;
          else w[(i*W+j)*DW +: DW] = img[sr][sc];
        end
`ifdef ZERO_PAD_EN
      emit = 1'b1;
`else
      emit = full;
`endif
      e.vld = emit;
      e.eof = (c == IW - 1) && (rw == IH - 1);
      e.col = 16'(c);
      e.row = 16'(rw);
      out_col = 16'(c);
      out_row = 16'(rw);
      if (emit) begin
        e.win = w;
        win_q.push_back(e);
        win_known = 1'b1;
        last_win = w;
      end else begin
        win_known = 1'b0;
      end
      m_col = (c == IW - 1) ? 0 : c + 1;
      m_row = (c == IW - 1) ? ((rw == IH - 1) ? 0 : rw + 1) : rw;
    end else begin
      e.col  = out_col;
      e.row  = out_row;
      e.chkw = win_known;
      e.win  = last_win;
    end
    cyc_q.push_back(e);
  endtask

  task automatic frame(input bit sof_first, input int gap_mode, input bit rnd, input int npix);
    logic [DW-1:0] d;
    int            n;
    n = 0;
    for (int r = 0; r < IH; r++)
      for (int c = 0; c < IW; c++)
        if (n < npix) begin
          d = rnd ? DW'($urandom) : DW'(16'h0100 + r * 4 + c);
          if (gap_mode == 1) step(1'b0, 1'b0, 1'b0, 16'hDEAD);
          if (gap_mode == 2 && $urandom_range(0, 2) == 0) step(1'b0, 1'b0, 1'b0, 16'hBEEF);
          step(1'b0, 1'b1, sof_first && r == 0 && c == 0, d);
          n++;
        end
  endtask

  task automatic chk(input string name, input logic [WB-1:0] act, input logic [WB-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @cyc %0d: got %0h required %0h", name, cyc_n, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    exp_t e, p;
    if (cyc_q.size() > 0 && cyc_q[0].cyc < cyc_n) begin
      e = cyc_q.pop_front();
      chk("valid_o", WB'(valid_o), WB'(e.vld));
      chk("eof_o", WB'(eof_o), WB'(e.eof));
      chk("col_o", WB'(col_o), WB'(e.col));
      chk("row_o", WB'(row_o), WB'(e.row));
      if (e.chkw) chk("window_hold", dut_win, e.win);
    end
    if (valid_o === 1'b1) begin
      if (win_q.size() == 0) begin
        chk("unexpected_valid", WB'(1), WB'(0));
      end else begin
        p = win_q.pop_front();
        chk("latency", WB'(cyc_n), WB'(p.cyc + 1));
        chk("window", dut_win, p.win);
        chk("win_col", WB'(col_o), WB'(p.col));
        chk("win_row", WB'(row_o), WB'(p.row));
      end
    end
    if (done) begin
      chk("cycle_queue_drained", WB'(cyc_q.size()), WB'(0));
      chk("window_queue_drained", WB'(win_q.size()), WB'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; sof_i = 1'b0; data_i = '0;
    step(1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    // Continuous pattern frame, no sof: first accept after reset is (0,0).
    frame(1'b0, 0, 1'b0, IW * IH);
    step(1'b0, 1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b0, 1'b0, 16'h0);
    // valid_i toggling every other cycle.
    frame(1'b1, 1, 1'b0, IW * IH);
    step(1'b0, 1'b0, 1'b0, 16'h0);
    // Aborted frame: six pixels, then sof on the seventh.
    frame(1'b1, 0, 1'b0, 6);
    frame(1'b1, 0, 1'b0, IW * IH);
    // Reset in the cycle of the sixth pixel, which is dropped; next frame without sof.
    frame(1'b1, 0, 1'b0, 5);
    step(1'b1, 1'b1, 1'b0, 16'h0105);
    step(1'b0, 1'b0, 1'b0, 16'h0);
    frame(1'b0, 0, 1'b0, IW * IH);
    // Back-to-back frames, the later ones relying on counter wrap.
    frame(1'b1, 0, 1'b0, IW * IH);
    frame(1'b0, 0, 1'b1, IW * IH);
    frame(1'b0, 0, 1'b1, IW * IH);
    frame(1'b1, 2, 1'b1, IW * IH);
    for (int n = 0; n < 700; n++) begin
      int x;
      x = $urandom_range(0, 199);
      if (x < 2) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, DW'($urandom));
      else if (x < 50) step(1'b0, 1'b0, 1'($urandom_range(0, 1)), DW'($urandom));
      else step(1'b0, 1'b1, ($urandom_range(0, 29) == 0), DW'($urandom));
    end
    step(1'b0, 1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b0, 1'b0, 16'h0);
    repeat (2) @(posedge clk_i);
    #1;
    done = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sliding_window_fp16.md
# sliding_window_fp16

Streaming window generator that turns a raster-order FP16 pixel stream into WINDOW_HEIGHT×WINDOW_WIDTH neighbourhoods with matching column/row tags and valid. It is the producer that feeds the window/col/row/valid inputs of the floating-point convolution passes. Internally it holds WINDOW_HEIGHT-1 line buffers, a tap shift register and frame position counters. It has no backpressure, matching the convolution pipeline.

## Interface
- EXP_WIDTH, 5, exponent bits
- FRAC_WIDTH, 10, fraction bits
- WINDOW_WIDTH, 3, window columns (≥2)
- WINDOW_HEIGHT, 3, window rows (≥2)
- IMG_WIDTH, 640, pixels per line (≥ WINDOW_WIDTH, ≤ 65535)
- IMG_HEIGHT, 480, lines per frame (≥ WINDOW_HEIGHT, ≤ 65535)
- FP_WIDTH_REG, 1+EXP_WIDTH+FRAC_WIDTH, local: word width

Ports:
- clk_i  in  1  sole clock; all logic on rising edge
- rst_i  in  1  reset; synchronous, active-high
- data_i  in  FP_WIDTH_REG  pixel
- valid_i  in  1  pixel accepted this cycle
- sof_i  in  1  qualifies by valid_i; this pixel is (col 0, row 0)
- window_o  out  FP_WIDTH_REG [WINDOW_HEIGHT][WINDOW_WIDTH]  [0][0] oldest row/column, [H-1][W-1] newest pixel
- col_o  out  16  column of newest pixel of the window
- row_o  out  16  row of newest pixel of the window
- valid_o  out  1  window_o/col_o/row_o valid
- eof_o  out  1  one-cycle pulse with the window of pixel (IMG_WIDTH-1, IMG_HEIGHT-1)

## Operation
- Position counters col_q/row_q give the coordinate of the next accepted pixel. On an accept: col_q wraps from IMG_WIDTH-1 to 0 and increments row_q; row_q wraps from IMG_HEIGHT-1 to 0. An accept with sof_i=1 is treated as (0,0), and the counters then advance to (1,0). This holds mid-frame too.
- Line buffers: WINDOW_HEIGHT-1 memories of depth IMG_WIDTH, addressed by col_q. On accept, buffer k is written with the value read from buffer k-1 (buffer 0 gets data_i). Read and write happen in the same cycle at the same address, read-before-write. Line buffer contents are never reset.
- Tap register: each row r of the window shifts left by one on accept. The new rightmost tap of row r is the pixel from row (row_q - (H-1-r)) at column col_q. Taps hold when valid_i=0.
- Window qualification: the window is complete when row ≥ WINDOW_HEIGHT-1 and col ≥ WINDOW_WIDTH-1, where (col,row) is the accepted pixel's coordinate. Behaviour for incomplete windows is set by the configuration macro.
- Floating-point values are passed through bit-exact; there is no arithmetic on the data.
- State machine frame_state:
  - IDLE: after reset; no pixel yet.
  - ACTIVE: entered on the first accept.
  - ACTIVE→IDLE on accept of pixel (IMG_WIDTH-1, IMG_HEIGHT-1).
  - Any state→ACTIVE on accept with sof_i.
  - eof_o fires on the IDLE transition; sof_i on that same pixel overrides it (no eof_o).

## Timing
- Latency: exactly 1 cycle. A pixel accepted in cycle N gives window_o/col_o/row_o/valid_o in cycle N+1.
- Throughput: one pixel per cycle, sustained across line and frame boundaries; no bubbles are required.
- valid_i=0 cycles: valid_o=0 next cycle; window_o/col_o/row_o hold their last values.
- Reset values: valid_o=0, eof_o=0, col_o=0, row_o=0, all window_o taps 16'h0000, counters 0, state IDLE.
- rst_i asserted mid-frame: outputs take reset values on the next cycle. The first accept after reset is at (0,0) regardless of sof_i.
- rst_i and valid_i in the same cycle: reset wins; the pixel is dropped.

## Configuration
- ZERO_PAD_EN defined:
  - valid_o follows every accepted pixel.
  - Taps whose source row < 0 or source column < 0 (relative to the newest pixel) are forced to +0.0 (all-zero word). This masks stale line-buffer and tap data at frame start, line start and after a mid-frame sof_i.
- ZERO_PAD_EN undefined:
  - valid_o=1 only for complete windows; no masking logic.
  - eof_o still fires, because pixel (IMG_WIDTH-1, IMG_HEIGHT-1) always completes a window.

## Test plan
Parameters for all scenarios: IMG_WIDTH=4, IMG_HEIGHT=3, 3×3 window, pixel value = 16'h0100+row*4+col.
- Continuous frame, no macro:
  - valid_o exactly twice: (col 2,row 2) and (3,2).
  - Window at (3,2) rows: {0101,0102,0103}, {0105,0106,0107}, {0109,010A,010B}.
  - eof_o only with (3,2).
- Same frame with ZERO_PAD_EN:
  - 12 valid_o pulses.
  - Window at (0,0) is all zero except [2][2]=16'h0100.
  - Window at (1,1): row 0 zero; [1][1..2]=0100,0101; [2][1..2]=0104,0105; column 0 zero.
- Gapped input: valid_i toggles every other cycle.
  - Windows match the continuous case.
  - Outputs hold during gaps.
  - Latency 1 cycle per pixel.
- Mid-frame sof_i at pixel 6, then a full frame:
  - No eof_o for the aborted frame.
  - The new frame's windows equal the continuous case (ZERO_PAD_EN: no stale data visible).
- rst_i in cycle 5, then a full frame:
  - Next cycle valid_o=0, window zeroed.
  - The following frame is correct without sof_i.
- Back-to-back frames:
  - eof_o at cycle of (3,2) window.
  - Next accept is (0,0).
  - No bubble in valid_o.
